// File: rtl/spi_frame_sender.sv
// -----------------------------------------------------------------------------
// spi_frame_sender
// Captures one packed game-state frame on a trigger pulse and shifts it out
// MSB-first as an SPI mode-0 master (CPOL=0, CPHA=0) towards the peer board.
//
// Optional build macro: SPI_PARITY_EN
//   defined   -> one even-parity bit (XOR of all data bits) follows the LSB
//   undefined -> exactly DATA_WIDTH bits per frame
// -----------------------------------------------------------------------------
module spi_frame_sender #(
    parameter int DATA_WIDTH      = 89,
    parameter int DATA_CLK_PERIOD = 20
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  trigger_in,
    output logic                  busy_out,
    output logic                  done_out,
    output logic                  chip_data_out,
    output logic                  chip_clk_out,
    output logic                  chip_sel_out
);

    // Number of SCLK periods in one frame.
`ifdef SPI_PARITY_EN
    localparam int N_BITS = DATA_WIDTH + 1;
`else
    localparam int N_BITS = DATA_WIDTH;
`endif

    localparam int HALF_PERIOD = DATA_CLK_PERIOD / 2;
    localparam int HALF_CNT_W  = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int BIT_CNT_W   = $clog2(N_BITS + 1);

    localparam logic [HALF_CNT_W-1:0] HALF_LAST = HALF_CNT_W'(HALF_PERIOD - 1);
    localparam logic [BIT_CNT_W-1:0]  BIT_LAST  = BIT_CNT_W'(N_BITS - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t                r_state;
    logic [N_BITS-1:0]     r_shift;
    logic [HALF_CNT_W-1:0] r_half_cnt;
    logic [BIT_CNT_W-1:0]  r_bit_cnt;
    logic                  r_sclk;
    logic                  r_cs_n;
    logic                  r_busy;
    logic                  r_done;

    logic [N_BITS-1:0]     w_frame;
    logic                  w_half_wrap;

    // Frame image loaded into the shift register when a trigger is accepted.
`ifdef SPI_PARITY_EN
    assign w_frame = {data_in, ^data_in};
`else
    assign w_frame = data_in;
`endif

    assign w_half_wrap = (r_half_cnt == HALF_LAST);

    // MOSI is the shift-register MSB. Shifting once more after the final bit
    // leaves the register all-zero, so MOSI idles low without a separate flop.
    assign chip_data_out = r_shift[N_BITS-1];
    assign chip_clk_out  = r_sclk;
    assign chip_sel_out  = r_cs_n;
    assign busy_out      = r_busy;
    assign done_out      = r_done;

    // Frame sequencer: trigger capture, SCLK generation and bit shifting.
    // NOTE: every register here uses non-blocking assignment so all updates
    // see the pre-edge values; mixing in blocking writes would make the
    // falling-edge shift depend on statement order.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_half_cnt <= '0;
            r_bit_cnt  <= '0;
            r_sclk     <= 1'b0;
            r_cs_n     <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (trigger_in) begin
                        r_shift    <= w_frame;
                        r_half_cnt <= '0;
                        r_bit_cnt  <= '0;
                        r_sclk     <= 1'b0;
                        r_cs_n     <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (!w_half_wrap) begin
                        r_half_cnt <= r_half_cnt + HALF_CNT_W'(1);
                    end else begin
                        r_half_cnt <= '0;
                        if (!r_sclk) begin
                            // Rising edge: data held, peer samples MOSI.
                            r_sclk <= 1'b1;
                        end else begin
                            // Falling edge: advance to the next bit.
                            r_sclk    <= 1'b0;
                            r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
                            r_shift   <= r_shift << 1;
                            if (r_bit_cnt == BIT_LAST) begin
                                r_state <= ST_IDLE;
                                r_cs_n  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule
